adc_seq_avg: RTL

ADC_SEQ_AVG -- requirements
Module: adc_seq_avg

---
 rtl/adc_seq_avg_if.sv | 21 ++
 rtl/adc_seq_avg.sv | 65 ++++++
 2 files changed

// File: rtl/adc_seq_avg_if.sv
// adc_seq_avg_if: decoder and result handshake signals of the averaging sequencer
interface adc_seq_avg_if;
  logic       start;
  logic [1:0] avg_sel;
  logic [2:0] code_in;
  logic       eoc_in;
  logic       samp_out;
  logic [2:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       err;
  modport master (
    output start, avg_sel, code_in, eoc_in, res_ready,
    input  samp_out, res_data, res_valid, busy, err
  );
  modport slave (
    input  start, avg_sel, code_in, eoc_in, res_ready,
    output samp_out, res_data, res_valid, busy, err
  );
endinterface

// File: rtl/adc_seq_avg.sv
// adc_seq_avg: flash-ADC sequencer averaging 1/2/4/8 samples with eoc timeout
module adc_seq_avg #(
  parameter int TMO = 8
) (
  input  logic           my_clk,
  input  logic           my_rst,
  inout  wire            vdd,
  inout  wire            vss,
  adc_seq_avg_if.slave   bus
);
  localparam int WW = $clog2(TMO + 1);
  typedef enum logic [1:0] {IDLE, SAMP, CONV, OUT} state_t;
  state_t        state, nxt;
  logic [5:0]    acc, sum;
  logic [2:0]    cnt, res;
  logic [1:0]    sel;
  logic [WW-1:0] wcnt;
  logic          err_q, hit, last, tmo;
  assign sum  = acc + {3'b000, bus.code_in};
  assign hit  = state == CONV && bus.eoc_in;
  assign last = cnt == 3'((4'd1 << sel) - 4'd1);
  assign tmo  = state == CONV && !bus.eoc_in && wcnt == WW'(TMO - 1);
  always_comb begin
    nxt = state == IDLE ? (bus.start ? SAMP : IDLE) :
          state == SAMP ? CONV :
          state == CONV ? (bus.eoc_in ? (last ? OUT : SAMP) : (tmo ? IDLE : CONV)) :
          (bus.res_ready ? IDLE : OUT);
  end
  always_ff @(posedge my_clk) begin
    if (my_rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sel   <= '0;
      wcnt  <= '0;
      res   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        sel   <= bus.avg_sel;
        acc   <= '0;
        cnt   <= '0;
        err_q <= 1'b0;
      end
      // CONV is only ever entered from SAMP, so this restarts the wait count on each entry
      if (state == SAMP) wcnt <= '0;
      if (state == CONV) wcnt <= wcnt + 1'b1;
      if (hit) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        if (last) res <= 3'(sum >> sel);
      end
      if (tmo) begin
        err_q <= 1'b1;
        acc   <= '0;
      end
    end
  end
  assign bus.samp_out  = state != CONV;
  assign bus.res_valid = state == OUT;
  assign bus.busy      = state != IDLE;
  assign bus.res_data  = res;
  assign bus.err       = err_q;
endmodule
